// File: rtl/instruction_fetch_unit_if.sv
`default_nettype none
// ============================================================================
// Module   : instruction_fetch_unit_if
// Purpose  : Memory, address-register-file and IR handshake bundle of the fetch unit.
// Revision : 1.0 - initial release
// ============================================================================
interface instruction_fetch_unit_if;
  logic        Start;
  logic [7:0]  Mem_Data;
  logic        Mem_Ready;
  logic        Mem_Rd;
  logic        ARF_E;
  logic [1:0]  ARF_FunSel;
  logic [2:0]  ARF_RegSel;
  logic [1:0]  ARF_OutDSel;
  logic [15:0] IR;
  logic        Busy;
  logic        Done;
  logic        Err;

  // Requester / environment side: memory, ARF and the decode stage
  modport master (
    output Start, Mem_Data, Mem_Ready,
    input  Mem_Rd, ARF_E, ARF_FunSel, ARF_RegSel, ARF_OutDSel, IR, Busy, Done, Err
  );

  // Fetch unit side
  modport slave (
    input  Start, Mem_Data, Mem_Ready,
    output Mem_Rd, ARF_E, ARF_FunSel, ARF_RegSel, ARF_OutDSel, IR, Busy, Done, Err
  );
endinterface
`default_nettype wire

// File: rtl/instruction_fetch_unit.sv
`default_nettype none
// ============================================================================
// Module   : instruction_fetch_unit
// Purpose  : Fetches one 16-bit instruction byte-by-byte at PC, advancing PC by 2.
// Revision : 1.0 - initial release
// ============================================================================
module instruction_fetch_unit #(
  parameter int MAX_WAIT = 15
) (
  input  wire                      clk,
  input  wire                      rst,
  instruction_fetch_unit_if.slave  bus
);

  localparam logic [7:0] c_max_wait   = 8'(MAX_WAIT);
  localparam logic [1:0] c_fun_inc    = 2'b01;
  localparam logic [2:0] c_sel_pc     = 3'b001;
  localparam logic [1:0] c_outd_pc    = 2'b00;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    FETCH_LO = 2'd1,
    FETCH_HI = 2'd2,
    DONE     = 2'd3
  } state_t;

  state_t      r_state;
  state_t      w_next_state;
  logic [7:0]  r_wait_cnt;
  logic [15:0] r_ir;
  logic        r_done;
  logic        r_err;

  logic w_fetching;
  logic w_accept;
  logic w_timeout;

  assign w_fetching = (r_state == FETCH_LO) || (r_state == FETCH_HI);
  assign w_accept   = w_fetching && bus.Mem_Ready;
  // Ready on the MAX_WAIT cycle still wins over the timeout
  assign w_timeout  = w_fetching && !bus.Mem_Ready && (r_wait_cnt == c_max_wait);

  always_comb begin
    w_next_state = r_state;
    unique case (r_state)
      IDLE:     if (bus.Start) w_next_state = FETCH_LO;
      FETCH_LO: begin
        if (w_accept)       w_next_state = FETCH_HI;
        else if (w_timeout) w_next_state = IDLE;
      end
      FETCH_HI: begin
        if (w_accept)       w_next_state = DONE;
        else if (w_timeout) w_next_state = IDLE;
      end
      DONE:     w_next_state = IDLE;
      default:  w_next_state = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state    <= IDLE;
      r_wait_cnt <= '0;
      r_ir       <= '0;
      r_done     <= 1'b0;
      r_err      <= 1'b0;
    end else begin
      r_state <= w_next_state;
      r_done  <= (w_next_state == DONE);
      r_err   <= w_timeout;

      // Any state change is an entry into a fresh wait window
      if (w_next_state != r_state)
        r_wait_cnt <= '0;
      else if (w_fetching && !bus.Mem_Ready)
        r_wait_cnt <= r_wait_cnt + 8'd1;

      if (w_accept && (r_state == FETCH_LO))
        r_ir[7:0] <= bus.Mem_Data;
      if (w_accept && (r_state == FETCH_HI))
        r_ir[15:8] <= bus.Mem_Data;
    end
  end

  // The ARF only ever sees an enable together with a PC increment
  assign bus.ARF_E       = w_accept;
  assign bus.ARF_RegSel  = w_accept ? c_sel_pc : 3'b000;
  assign bus.ARF_FunSel  = c_fun_inc;
  assign bus.ARF_OutDSel = c_outd_pc;
  assign bus.Mem_Rd      = w_fetching;
  assign bus.Busy        = w_fetching;
  assign bus.IR          = r_ir;
  assign bus.Done        = r_done;
  assign bus.Err         = r_err;

endmodule
`default_nettype wire

// File: tb/tb_instruction_fetch_unit.sv
`default_nettype none
// ============================================================================
// Module   : tb_instruction_fetch_unit
// Purpose  : Self-checking bench: ARF/memory model, directed table and random fetches.
// Revision : 1.0 - initial release
// ============================================================================
module tb_instruction_fetch_unit;

  localparam int MAXW = 3;

  typedef struct {
    logic [15:0] pc;
    int          wlo;
    int          whi;
    bit          spam;
    logic [15:0] exp_ir;
    logic [15:0] exp_pc;
    int          exp_done;
    int          exp_err;
    int          exp_pulses;
  } vec_t;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [15:0] pc = 16'h0000;
  logic        pc_load = 1'b0;
  logic [15:0] pc_val = 16'h0000;
  logic [7:0]  mem [256];
  logic [15:0] model_ir = 16'h0000;
  int          n_pass = 0;
  int          n_total = 0;
  int          e_count = 0;
  int          viol = 0;

  instruction_fetch_unit_if bus ();

  instruction_fetch_unit #(.MAX_WAIT(MAXW)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  assign bus.Mem_Data = mem[pc[7:0]];

  // Address register file: only PC is modelled
  always @(posedge clk) begin
    if (pc_load)
      pc <= pc_val;
    else if (bus.ARF_E && bus.ARF_RegSel[0]) begin
      case (bus.ARF_FunSel)
        2'b00:   pc <= pc - 16'd1;
        2'b01:   pc <= pc + 16'd1;
        2'b11:   pc <= 16'h0000;
        default: pc <= pc;
      endcase
    end
  end

  // Protocol monitor on the ARF control lines
  always @(posedge clk) begin
    if (bus.ARF_E) begin
      e_count <= e_count + 1;
      if (bus.ARF_RegSel != 3'b001 || !bus.Mem_Ready) viol <= viol + 1;
    end else if (bus.ARF_RegSel != 3'b000) viol <= viol + 1;
    if (bus.ARF_FunSel != 2'b01 || bus.ARF_OutDSel != 2'b00 || bus.Mem_Rd != bus.Busy)
      viol <= viol + 1;
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  // Reference: outcome of one fetch from the wait counts alone
  function automatic vec_t build(input logic [15:0] p, input int wlo, input int whi, input bit spam);
    vec_t v;
    logic [15:0] p1;
    p1 = p + 16'd1;
    v.pc = p; v.wlo = wlo; v.whi = whi; v.spam = spam;
    v.exp_done = 0; v.exp_err = 0;
    if (wlo > MAXW) begin
      v.exp_ir = model_ir; v.exp_pc = p; v.exp_err = MAXW + 2; v.exp_pulses = 0;
    end else if (whi > MAXW) begin
      v.exp_ir = {model_ir[15:8], mem[p[7:0]]}; v.exp_pc = p1;
      v.exp_err = wlo + 1 + MAXW + 1 + 1; v.exp_pulses = 1;
    end else begin
      v.exp_ir = {mem[p1[7:0]], mem[p[7:0]]}; v.exp_pc = p + 16'd2;
      v.exp_done = wlo + whi + 3; v.exp_pulses = 2;
    end
    return v;
  endfunction

  task automatic apply(input vec_t v, input string tag);
    int e0, v0, ndone, nerr, fdone, ferr, last;
    bit lo_ok, hi_ok, r;
    lo_ok = (v.wlo <= MAXW);
    hi_ok = lo_ok && (v.whi <= MAXW);
    last  = (v.exp_done != 0) ? v.exp_done : v.exp_err;
    ndone = 0; nerr = 0; fdone = 0; ferr = 0;
    @(negedge clk);
    pc_load = 1'b1; pc_val = v.pc; bus.Start = 1'b0; bus.Mem_Ready = 1'b0;
    @(negedge clk);
    pc_load = 1'b0; bus.Start = 1'b1;
    e0 = e_count; v0 = viol;
    for (int k = 1; k <= last + 3; k++) begin
      @(negedge clk);
      if (v.spam && (k < last || (k == last && v.exp_done != 0)))
        bus.Start = 1'($urandom % 2);
      else
        bus.Start = 1'b0;
      r = (lo_ok && k == v.wlo + 1) || (hi_ok && k == v.wlo + 2 + v.whi);
      if (k > last) r = 1'($urandom % 2);
      bus.Mem_Ready = r;
      #1;
      if (bus.Done) begin ndone++; if (fdone == 0) fdone = k; end
      if (bus.Err)  begin nerr++;  if (ferr == 0)  ferr = k;  end
    end
    @(negedge clk);
    bus.Mem_Ready = 1'b0;
    #1;
    check({tag, " done_cycle"}, 32'(fdone), 32'(v.exp_done));
    check({tag, " done_count"}, 32'(ndone), (v.exp_done != 0) ? 32'd1 : 32'd0);
    check({tag, " err_cycle"}, 32'(ferr), 32'(v.exp_err));
    check({tag, " err_count"}, 32'(nerr), (v.exp_err != 0) ? 32'd1 : 32'd0);
    check({tag, " ir"}, {16'h0, bus.IR}, {16'h0, v.exp_ir});
    check({tag, " pc"}, {16'h0, pc}, {16'h0, v.exp_pc});
    check({tag, " arf_e_pulses"}, 32'(e_count - e0), 32'(v.exp_pulses));
    check({tag, " arf_protocol"}, 32'(viol - v0), 32'd0);
    model_ir = v.exp_ir;
  endtask

  vec_t dir [6];

  initial begin
    int e0;
    vec_t v;
    for (int i = 0; i < 256; i++) mem[i] = 8'($urandom);
    mem[8'h10] = 8'h34; mem[8'h11] = 8'h12;
    mem[8'h20] = 8'hCD; mem[8'h21] = 8'hAB;
    mem[8'h30] = 8'h5A; mem[8'h31] = 8'hA5;
    //         pc       wlo whi spam ir        pc_after  done err pulses
    dir[0] = '{16'h0010, 0, 0, 1'b0, 16'h1234, 16'h0012, 3, 0, 2};  // zero wait
    dir[1] = '{16'h0020, 2, 2, 1'b0, 16'hABCD, 16'h0022, 7, 0, 2};  // wait states
    dir[2] = '{16'h0030, 0, 4, 1'b0, 16'hAB5A, 16'h0031, 0, 6, 1};  // timeout in FETCH_HI
    dir[3] = '{16'h0010, 3, 0, 1'b0, 16'h1234, 16'h0012, 6, 0, 2};  // ready on the MAX_WAIT cycle
    dir[4] = '{16'h0020, 1, 0, 1'b1, 16'hABCD, 16'h0022, 4, 0, 2};  // Start while busy and in DONE
    dir[5] = '{16'h0040, 5, 0, 1'b0, 16'hABCD, 16'h0040, 0, 5, 0};  // timeout in FETCH_LO

    bus.Start = 1'b0;
    bus.Mem_Ready = 1'b1;
    repeat (3) @(negedge clk);
    #1;
    check("rst busy", 32'(bus.Busy), 32'd0);
    check("rst done", 32'(bus.Done), 32'd0);
    check("rst err", 32'(bus.Err), 32'd0);
    check("rst mem_rd", 32'(bus.Mem_Rd), 32'd0);
    check("rst arf_e", 32'(bus.ARF_E), 32'd0);
    check("rst regsel", 32'(bus.ARF_RegSel), 32'd0);
    check("rst funsel", 32'(bus.ARF_FunSel), 32'd1);
    check("rst outdsel", 32'(bus.ARF_OutDSel), 32'd0);
    check("rst ir", 32'(bus.IR), 32'd0);
    rst = 1'b0;
    bus.Mem_Ready = 1'b0;

    for (int i = 0; i < 6; i++) apply(dir[i], $sformatf("dir%0d", i));

    for (int i = 0; i < 40; i++) begin
      v = build((i == 0) ? 16'hFFFF : 16'($urandom), int'($urandom_range(0, 4)),
                int'($urandom_range(0, 4)), 1'($urandom % 2));
      apply(v, $sformatf("rnd%0d", i));
    end

    // Reset while in FETCH_HI
    @(negedge clk);
    pc_load = 1'b1; pc_val = 16'h0050;
    @(negedge clk);
    pc_load = 1'b0; bus.Start = 1'b1;
    @(negedge clk);
    bus.Start = 1'b0; bus.Mem_Ready = 1'b1;
    @(negedge clk);
    bus.Mem_Ready = 1'b0; rst = 1'b1;
    #1;
    check("midrst busy_before", 32'(bus.Busy), 32'd1);
    @(negedge clk);
    rst = 1'b0;
    #1;
    e0 = e_count;
    check("midrst busy", 32'(bus.Busy), 32'd0);
    check("midrst done", 32'(bus.Done), 32'd0);
    check("midrst err", 32'(bus.Err), 32'd0);
    check("midrst mem_rd", 32'(bus.Mem_Rd), 32'd0);
    check("midrst arf_e", 32'(bus.ARF_E), 32'd0);
    check("midrst regsel", 32'(bus.ARF_RegSel), 32'd0);
    check("midrst ir", 32'(bus.IR), 32'd0);
    bus.Mem_Ready = 1'b1;
    repeat (5) @(negedge clk);
    bus.Mem_Ready = 1'b0;
    #1;
    check("midrst no_arf_e", 32'(e_count - e0), 32'd0);
    check("midrst pc", 32'(pc), 32'h0051);
    model_ir = 16'h0000;
    apply(build(16'h0020, 0, 1, 1'b0), "post_rst");

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/instruction_fetch_unit.md
# instruction_fetch_unit

Sequencer that fetches one 16-bit instruction from byte-wide memory, using the address register file's PC as the fetch address. It drives the address register file's control inputs: E, FunSel, RegSel and OutDSel. OutD is routed to the memory address bus. The block assembles the two fetched bytes into an instruction register and advances PC by 2. It sits between the address register file (upstream address source) and the decode/control stage (downstream consumer of IR).

## Interface
- MAX_WAIT, default 15: maximum cycles a fetch state waits for Mem_Ready before aborting (1..255).
- clk  in  1  system clock; all state changes on rising edge.
- rst  in  1  synchronous, active-high reset.
- Start  in  1  request one instruction fetch; sampled only in IDLE.
- Mem_Data  in  8  memory read data, valid when Mem_Ready=1.
- Mem_Ready  in  1  memory has valid data for the current address this cycle.
- Mem_Rd  out  1  memory read strobe.
- ARF_E  out  1  enable to the address register file.
- ARF_FunSel  out  2  FunSel to the address register file: 00 dec, 01 inc, 10 load, 11 clear.
- ARF_RegSel  out  3  RegSel to the address register file: bit0 PC, bit1 AR, bit2 SP.
- ARF_OutDSel  out  2  OutD select to the address register file; 00 selects PC.
- IR  out  16  fetched instruction, {high byte, low byte}.
- Busy  out  1  fetch in progress.
- Done  out  1  one-cycle pulse; IR holds a complete new instruction.
- Err  out  1  one-cycle pulse; fetch aborted on timeout.

## Operation
- States: IDLE, FETCH_LO, FETCH_HI, DONE.
- IDLE behaviour:
  - Start=1 moves the FSM to FETCH_LO.
  - Start=0 keeps it in IDLE.
- FETCH_LO and FETCH_HI outputs: Mem_Rd=1, ARF_OutDSel=00 and Busy=1.
- Wait counter:
  - Cleared on entry to each fetch state.
  - Increments on every cycle in a fetch state with Mem_Ready=0.
- Fetch state with Mem_Ready=1, all in the same cycle:
  - ARF_E=1, ARF_RegSel=001, ARF_FunSel=01, so PC increments at that edge.
  - The byte is captured: IR[7:0] in FETCH_LO, IR[15:8] in FETCH_HI.
  - The FSM advances: FETCH_LO goes to FETCH_HI, FETCH_HI goes to DONE.
- Timeout: Mem_Ready=0 while the wait counter equals MAX_WAIT:
  - Return to IDLE and pulse Err for one cycle, in the IDLE cycle.
  - PC is not incremented in that cycle.
  - IR keeps any byte already captured.
- DONE: Done=1 and Busy=0, then IDLE unconditionally.
- Start is ignored outside IDLE, including in DONE; no request queuing.
- Outside a Mem_Ready=1 fetch cycle: ARF_E=0, ARF_RegSel=000, ARF_FunSel=01. The ARF must never see E=1 with a nonzero RegSel except on an increment.
- Mem_Rd=0 outside the fetch states.
- Outside the fetch states, ARF_OutDSel stays at 00.
- The IR high byte is never written before its low byte within a fetch.

## Timing
- Reset values:
  - State IDLE, IR=16'h0000, wait counter 0.
  - Busy=0, Done=0, Err=0, Mem_Rd=0, ARF_E=0, ARF_RegSel=000, ARF_FunSel=01, ARF_OutDSel=00.
- rst=1 in any state returns to IDLE at the next edge with the reset values above. Because ARF_E drops with it, no partial PC increment follows.
- All ARF_* outputs, Mem_Rd and Busy are combinational from state and Mem_Ready. IR, Done, Err and the state are registered.
- Zero-wait memory (Mem_Ready held 1), Start=1 sampled at edge 0:
  - Cycle 1: FETCH_LO.
  - Cycle 2: FETCH_HI.
  - Cycle 3: DONE with Done=1 and the new IR.
  - Cycle 4: IDLE.
  - Fetch latency is 3 cycles; the next accepted Start is sampled at the end of cycle 4.
- Each wait cycle adds exactly one cycle per fetch state.
- Mem_Ready=1 on the same cycle the counter hits MAX_WAIT: data is accepted, not a timeout.
- Timeout: the state remains a fetch state for MAX_WAIT+1 cycles, then IDLE with Err=1.
- PC wrap-around (16'hFFFF+1 = 0) is handled by the ARF; this block simply continues.

## Test plan
- Zero-wait fetch:
  - Setup: PC=16'h0010, memory[0x10]=8'h34, memory[0x11]=8'h12, Start pulsed.
  - Expected: Done rises exactly 3 cycles later with IR=16'h1234, PC=16'h0012, and exactly two ARF_E pulses, each with RegSel=001 and FunSel=01.
- Wait states:
  - Setup: Mem_Ready low for 2 cycles in each fetch state.
  - Expected: Done 7 cycles after Start, correct IR, PC+2, and no ARF_E while Mem_Ready=0.
- Timeout:
  - Setup: MAX_WAIT=3, Mem_Ready stuck 0 in FETCH_HI after the low byte is accepted.
  - Expected: Err pulses once, Done never rises, PC is +1 only, and IR[7:0] holds the low byte.
- Boundary at MAX_WAIT:
  - Setup: MAX_WAIT=3, Mem_Ready=1 exactly on the 4th FETCH_LO cycle.
  - Expected: byte accepted and no Err.
- Start while busy and in DONE:
  - Expected: ignored; only one fetch is performed and PC advances by 2.
- Reset mid-fetch:
  - Setup: rst=1 for 1 cycle in FETCH_HI.
  - Expected: next cycle shows IDLE, IR=0, all outputs at reset values, and no further ARF_E. A later Start fetches normally.
